// File: rtl/sram_port_arbiter.sv
// Two-master arbiter in front of a single-port SRAM.
// It accepts one request at a time, alternating between the masters when both
// are waiting. It drives one SRAM access and returns one response to the
// master that made the request. Illegal requests are answered as denied and
// never reach the SRAM.
module sram_port_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int SRAM_AW = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // master 0 (Dcache)
   input  logic                  m0_a_valid,
   output logic                  m0_a_ready,
   input  logic [2:0]            m0_a_opcode,
   input  logic [3:0]            m0_a_size,
   input  logic [DATA_W/8-1:0]   m0_a_mask,
   input  logic [ADDR_W-1:0]     m0_a_address,
   input  logic [DATA_W-1:0]     m0_a_data,
   input  logic [4:0]            m0_a_source,
   output logic                  m0_d_valid,
   input  logic                  m0_d_ready,
   // master 1 (Icache)
   input  logic                  m1_a_valid,
   output logic                  m1_a_ready,
   input  logic [2:0]            m1_a_opcode,
   input  logic [3:0]            m1_a_size,
   input  logic [DATA_W/8-1:0]   m1_a_mask,
   input  logic [ADDR_W-1:0]     m1_a_address,
   input  logic [DATA_W-1:0]     m1_a_data,
   input  logic [4:0]            m1_a_source,
   output logic                  m1_d_valid,
   input  logic                  m1_d_ready,
   // shared response fields
   output logic [2:0]            d_opcode,
   output logic [DATA_W-1:0]     d_data,
   output logic [4:0]            d_source,
   output logic [3:0]            d_size,
   output logic                  d_denied,
   output logic                  d_corrupt,
   // SRAM macro
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [SRAM_AW-1:0]    sram_addr,
   output logic [DATA_W-1:0]     sram_wdata,
   output logic [DATA_W/8-1:0]   sram_wmask,
   input  logic [DATA_W-1:0]     sram_rdata
);

   localparam int MW = DATA_W / 8;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_RESP} state_t;

   state_t              r_state;
   logic                r_last;      // master served most recently
   logic                r_master;    // master owning the transaction in flight
   logic [2:0]          r_opcode;
   logic [3:0]          r_size;
   logic [4:0]          r_source;
   logic                r_sram_en;
   logic                r_sram_we;
   logic [SRAM_AW-1:0]  r_sram_addr;
   logic [DATA_W-1:0]   r_sram_wdata;
   logic [MW-1:0]       r_sram_wmask;
   logic                r_m0_d_valid;
   logic                r_m1_d_valid;
   logic [2:0]          r_d_opcode;
   logic [DATA_W-1:0]   r_d_data;
   logic [4:0]          r_d_source;
   logic [3:0]          r_d_size;
   logic                r_d_denied;

   logic                w_grant_vld;
   logic                w_grant;
   logic [2:0]          w_sel_opcode;
   logic [3:0]          w_sel_size;
   logic [MW-1:0]       w_sel_mask;
   logic [ADDR_W-1:0]   w_sel_address;
   logic [DATA_W-1:0]   w_sel_data;
   logic [4:0]          w_sel_source;
   logic                w_legal;
   logic                w_resp_ready;
   logic                w_unused_addr;

   // Round-robin pick: a lone requester wins, a tie goes to the master not served last
   always_comb begin
      w_grant_vld = m0_a_valid | m1_a_valid;
      if (m0_a_valid && m1_a_valid) begin
         w_grant = ~r_last;
      end else begin
         w_grant = m1_a_valid;
      end
   end

   // Route the granted master's request fields to the latch inputs
   always_comb begin
      if (w_grant) begin
         w_sel_opcode  = m1_a_opcode;
         w_sel_size    = m1_a_size;
         w_sel_mask    = m1_a_mask;
         w_sel_address = m1_a_address;
         w_sel_data    = m1_a_data;
         w_sel_source  = m1_a_source;
      end else begin
         w_sel_opcode  = m0_a_opcode;
         w_sel_size    = m0_a_size;
         w_sel_mask    = m0_a_mask;
         w_sel_address = m0_a_address;
         w_sel_data    = m0_a_data;
         w_sel_source  = m0_a_source;
      end
   end

   assign w_legal       = ((w_sel_opcode == 3'd0) || (w_sel_opcode == 3'd4)) && (w_sel_size == 4'd2);
   assign w_resp_ready  = r_master ? m1_d_ready : m0_d_ready;
   assign w_unused_addr = ^{w_sel_address[ADDR_W-1:SRAM_AW+2], w_sel_address[1:0]};

   // a_ready is held low while reset is asserted so every output reads 0 in reset
   assign m0_a_ready = rst_n & (r_state == S_IDLE) & w_grant_vld & ~w_grant;
   assign m1_a_ready = rst_n & (r_state == S_IDLE) & w_grant_vld &  w_grant;

   // Transaction sequencer: accept, drive SRAM, capture read data, hold response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_last       <= 1'b1;
         r_master     <= 1'b0;
         r_opcode     <= '0;
         r_size       <= '0;
         r_source     <= '0;
         r_sram_en    <= 1'b0;
         r_sram_we    <= 1'b0;
         r_sram_addr  <= '0;
         r_sram_wdata <= '0;
         r_sram_wmask <= '0;
         r_m0_d_valid <= 1'b0;
         r_m1_d_valid <= 1'b0;
         r_d_opcode   <= '0;
         r_d_data     <= '0;
         r_d_source   <= '0;
         r_d_size     <= '0;
         r_d_denied   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_vld) begin
                  r_master <= w_grant;
                  r_last   <= w_grant;
                  r_opcode <= w_sel_opcode;
                  r_size   <= w_sel_size;
                  r_source <= w_sel_source;
                  if (w_legal) begin
                     r_state      <= S_ACCESS;
                     r_sram_en    <= 1'b1;
                     r_sram_we    <= (w_sel_opcode == 3'd0);
                     r_sram_addr  <= w_sel_address[SRAM_AW+1:2];
                     r_sram_wdata <= w_sel_data;
                     r_sram_wmask <= (w_sel_opcode == 3'd0) ? w_sel_mask : '0;
                  end else begin
                     // Denied: skip the SRAM entirely and answer next cycle
                     r_state      <= S_RESP;
                     r_m0_d_valid <= ~w_grant;
                     r_m1_d_valid <= w_grant;
                     r_d_opcode   <= 3'd0;
                     r_d_data     <= '0;
                     r_d_source   <= w_sel_source;
                     r_d_size     <= w_sel_size;
                     r_d_denied   <= 1'b1;
                  end
               end
            end
            S_ACCESS: begin
               r_sram_en    <= 1'b0;
               r_sram_we    <= 1'b0;
               r_sram_wmask <= '0;
               if (r_opcode == 3'd4) begin
                  r_state <= S_CAPTURE;
               end else begin
                  r_state      <= S_RESP;
                  r_m0_d_valid <= ~r_master;
                  r_m1_d_valid <= r_master;
                  r_d_opcode   <= 3'd0;
                  r_d_data     <= '0;
                  r_d_source   <= r_source;
                  r_d_size     <= r_size;
                  r_d_denied   <= 1'b0;
               end
            end
            S_CAPTURE: begin
               r_state      <= S_RESP;
               r_m0_d_valid <= ~r_master;
               r_m1_d_valid <= r_master;
               r_d_opcode   <= 3'd1;
               r_d_data     <= sram_rdata;
               r_d_source   <= r_source;
               r_d_size     <= r_size;
               r_d_denied   <= 1'b0;
            end
            S_RESP: begin
               // Only the owning master's d_ready can close the response
               if (w_resp_ready) begin
                  r_state      <= S_IDLE;
                  r_m0_d_valid <= 1'b0;
                  r_m1_d_valid <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign m0_d_valid = r_m0_d_valid;
   assign m1_d_valid = r_m1_d_valid;
   assign d_opcode   = r_d_opcode;
   assign d_data     = r_d_data;
   assign d_source   = r_d_source;
   assign d_size     = r_d_size;
   assign d_denied   = r_d_denied;
   assign d_corrupt  = 1'b0;
   assign sram_en    = r_sram_en;
   assign sram_we    = r_sram_we;
   assign sram_addr  = r_sram_addr;
   assign sram_wdata = r_sram_wdata;
   assign sram_wmask = r_sram_wmask;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: drivers push expected SRAM accesses
// and responses into queues, and a monitor pops and compares them as the DUT
// presents them.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_a_valid, m1_a_valid;
   logic        m0_a_ready, m1_a_ready;
   logic [2:0]  m0_a_opcode, m1_a_opcode;
   logic [3:0]  m0_a_size, m1_a_size;
   logic [3:0]  m0_a_mask, m1_a_mask;
   logic [31:0] m0_a_address, m1_a_address;
   logic [31:0] m0_a_data, m1_a_data;
   logic [4:0]  m0_a_source, m1_a_source;
   logic        m0_d_valid, m1_d_valid;
   logic        m0_d_ready, m1_d_ready;
   logic [2:0]  d_opcode;
   logic [31:0] d_data;
   logic [4:0]  d_source;
   logic [3:0]  d_size;
   logic        d_denied, d_corrupt;
   logic        sram_en, sram_we;
   logic [11:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [3:0]  sram_wmask;
   logic [31:0] sram_rdata;

   sram_port_arbiter #(.DATA_W(32), .ADDR_W(32), .SRAM_AW(12)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
      .m0_a_size(m0_a_size), .m0_a_mask(m0_a_mask), .m0_a_address(m0_a_address),
      .m0_a_data(m0_a_data), .m0_a_source(m0_a_source),
      .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
      .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
      .m1_a_size(m1_a_size), .m1_a_mask(m1_a_mask), .m1_a_address(m1_a_address),
      .m1_a_data(m1_a_data), .m1_a_source(m1_a_source),
      .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
      .d_opcode(d_opcode), .d_data(d_data), .d_source(d_source), .d_size(d_size),
      .d_denied(d_denied), .d_corrupt(d_corrupt),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural SRAM macro: read data appears the cycle after the strobe
   logic [31:0] mem [0:4095];
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++) begin
               if (sram_wmask[b]) mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
            end
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   typedef struct {
      int          master;
      logic [2:0]  op;
      logic [31:0] data;
      logic [4:0]  src;
      logic [3:0]  size;
      logic        denied;
      int          vcyc;
   } dexp_t;

   typedef struct {
      int          cyc;
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } sexp_t;

   dexp_t dq[$];
   sexp_t sq[$];
   int    grant_m[$];
   int    grant_t[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    t0, t1, hs_cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_a(input int m, input logic v, input logic [2:0] op, input logic [3:0] sz,
                        input logic [3:0] mk, input logic [31:0] ad, input logic [31:0] da);
      if (m == 0) begin
         m0_a_valid = v; m0_a_opcode = op; m0_a_size = sz; m0_a_mask = mk;
         m0_a_address = ad; m0_a_data = da; m0_a_source = 5'd1;
      end else begin
         m1_a_valid = v; m1_a_opcode = op; m1_a_size = sz; m1_a_mask = mk;
         m1_a_address = ad; m1_a_data = da; m1_a_source = 5'd2;
      end
   endtask

   // Present one request (caller is just after a rising edge), wait for the
   // handshake, log the expected SRAM access and response, then drop valid.
   task automatic issue(input int m, input logic [2:0] op, input logic [3:0] sz,
                        input logic [3:0] mk, input logic [31:0] ad, input logic [31:0] da,
                        input logic [31:0] exp_d, output int t_acc);
      int    guard;
      logic  legal;
      logic  rdy;
      dexp_t e;
      sexp_t s;
      set_a(m, 1'b1, op, sz, mk, ad, da);
      guard = 0;
      t_acc = -1;
      forever begin
         @(negedge clk);
         rdy = (m == 0) ? m0_a_ready : m1_a_ready;
         if (rdy) break;
         guard++;
         if (guard > 50) break;
      end
      if (!rdy) begin
         chk("accept_timeout", 32'd0, 32'd1);
         set_a(m, 1'b0, op, sz, mk, ad, da);
         return;
      end
      t_acc = cyc;
      grant_m.push_back(m);
      grant_t.push_back(cyc);
      legal = ((op == 3'd0) || (op == 3'd4)) && (sz == 4'd2);
      if (legal) begin
         s.cyc = cyc + 1; s.we = (op == 3'd0); s.addr = ad[13:2];
         s.wdata = da; s.wmask = (op == 3'd0) ? mk : 4'h0;
         sq.push_back(s);
      end
      e.master = m;
      e.op     = (legal && op == 3'd4) ? 3'd1 : 3'd0;
      e.data   = (legal && op == 3'd4) ? exp_d : 32'h0;
      e.src    = (m == 0) ? 5'd1 : 5'd2;
      e.size   = sz;
      e.denied = !legal;
      e.vcyc   = cyc + (!legal ? 1 : (op == 3'd4 ? 3 : 2));
      dq.push_back(e);
      @(posedge clk);
      #1;
      set_a(m, 1'b0, op, sz, mk, ad, da);
   endtask

   // Monitor: every cycle compare SRAM strobes and the presented response
   logic  in_resp = 1'b0;
   always @(negedge clk) begin
      dexp_t e;
      sexp_t s;
      int    mv;
      logic  dr;
      if (!rst_n) begin
         in_resp = 1'b0;
      end else begin
         if (sram_en) begin
            if (sq.size() == 0) begin
               chk("sram_en_unexpected", 32'd1, 32'd0);
            end else begin
               s = sq.pop_front();
               chk("sram_cycle", cyc, s.cyc);
               chk("sram_we", {31'd0, sram_we}, {31'd0, s.we});
               chk("sram_addr", {20'd0, sram_addr}, {20'd0, s.addr});
               chk("sram_wdata", sram_wdata, s.wdata);
               chk("sram_wmask", {28'd0, sram_wmask}, {28'd0, s.wmask});
            end
         end
         if (m0_d_valid && m1_d_valid) chk("d_valid_both", 32'd1, 32'd0);
         if (m0_d_valid || m1_d_valid) begin
            mv = m1_d_valid ? 1 : 0;
            dr = m1_d_valid ? m1_d_ready : m0_d_ready;
            if (dq.size() == 0) begin
               chk("d_valid_unexpected", 32'd1, 32'd0);
            end else begin
               e = dq[0];
               if (!in_resp) begin
                  in_resp = 1'b1;
                  chk("d_latency", cyc, e.vcyc);
                  chk("d_master", mv, e.master);
               end
               chk("d_opcode", {29'd0, d_opcode}, {29'd0, e.op});
               chk("d_data", d_data, e.data);
               chk("d_source", {27'd0, d_source}, {27'd0, e.src});
               chk("d_size", {28'd0, d_size}, {28'd0, e.size});
               chk("d_denied", {31'd0, d_denied}, {31'd0, e.denied});
               chk("d_corrupt", {31'd0, d_corrupt}, 32'd0);
               if (dr) begin
                  void'(dq.pop_front());
                  in_resp = 1'b0;
               end
            end
         end
      end
   end

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_m0_a_ready"}, {31'd0, m0_a_ready}, 32'd0);
      chk({tag, "_m1_a_ready"}, {31'd0, m1_a_ready}, 32'd0);
      chk({tag, "_m0_d_valid"}, {31'd0, m0_d_valid}, 32'd0);
      chk({tag, "_m1_d_valid"}, {31'd0, m1_d_valid}, 32'd0);
      chk({tag, "_sram_en"}, {31'd0, sram_en}, 32'd0);
      chk({tag, "_sram_we"}, {31'd0, sram_we}, 32'd0);
      chk({tag, "_sram_addr"}, {20'd0, sram_addr}, 32'd0);
      chk({tag, "_sram_wdata"}, sram_wdata, 32'd0);
      chk({tag, "_sram_wmask"}, {28'd0, sram_wmask}, 32'd0);
      chk({tag, "_d_opcode"}, {29'd0, d_opcode}, 32'd0);
      chk({tag, "_d_data"}, d_data, 32'd0);
      chk({tag, "_d_source"}, {27'd0, d_source}, 32'd0);
      chk({tag, "_d_size"}, {28'd0, d_size}, 32'd0);
      chk({tag, "_d_denied"}, {31'd0, d_denied}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int w = 0; w < 4096; w++) mem[w] = 32'h0;
      mem[4] = 32'hDEADBEEF;
      mem[2] = 32'hAABBCCDD;
      for (int k = 0; k < 11; k++) mem[16 + k] = 32'hA000_0010 + k;

      rst_n = 1'b0;
      set_a(0, 1'b0, 3'd0, 4'd0, 4'h0, 32'h0, 32'h0);
      set_a(1, 1'b0, 3'd0, 4'd0, 4'h0, 32'h0, 32'h0);
      m0_d_ready = 1'b1;
      m1_d_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: m0 Get of SRAM word 4
      issue(0, 3'd4, 4'd2, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, t0);
      repeat (4) @(posedge clk); #1;

      // 2: m1 partial Put to word 2
      issue(1, 3'd0, 4'd2, 4'b0011, 32'h8, 32'h12345678, 32'h0, t1);
      repeat (3) @(posedge clk); #1;

      // 3: both masters stream 4 Gets each; grants must alternate starting with m0
      grant_m.delete();
      grant_t.delete();
      fork
         begin
            for (int i = 0; i < 4; i++)
               issue(0, 3'd4, 4'd2, 4'h0, 32'h40 + 4*i, 32'h0, 32'hA000_0010 + i, t0);
         end
         begin
            for (int i = 0; i < 4; i++)
               issue(1, 3'd4, 4'd2, 4'h0, 32'h50 + 4*i, 32'h0, 32'hA000_0014 + i, t1);
         end
      join
      chk("rr_count", grant_m.size(), 8);
      if (grant_m.size() == 8) begin
         chk("rr_first", grant_m[0], 0);
         for (int i = 1; i < 8; i++) begin
            chk("rr_alternate", grant_m[i], 1 - grant_m[i-1]);
            chk("b2b_spacing", grant_t[i] - grant_t[i-1], 4);
         end
      end
      repeat (4) @(posedge clk); #1;

      // 4: illegal opcode, then illegal size
      issue(0, 3'd2, 4'd2, 4'h0, 32'h10, 32'h0, 32'h0, t0);
      issue(0, 3'd4, 4'd3, 4'h0, 32'h10, 32'h0, 32'h0, t0);
      repeat (2) @(posedge clk); #1;

      // readback of the masked Put: upper bytes untouched
      issue(0, 3'd4, 4'd2, 4'h0, 32'h8, 32'h0, 32'hAABB5678, t0);
      repeat (4) @(posedge clk); #1;

      // 5: m1 response stalled 5 cycles while m0 waits
      m1_d_ready = 1'b0;
      hs_cyc = -1;
      fork
         issue(1, 3'd0, 4'd2, 4'hF, 32'h30, 32'hCAFEF00D, 32'h0, t1);
         begin
            @(posedge clk); #1;
            issue(0, 3'd4, 4'd2, 4'h0, 32'h30, 32'h0, 32'hCAFEF00D, t0);
         end
         begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (!m1_d_valid && guard < 20) begin
               @(negedge clk);
               guard++;
            end
            chk("stall_resp_seen", {31'd0, m1_d_valid}, 32'd1);
            for (int k = 0; k < 5; k++) begin
               chk("stall_m0_a_ready", {31'd0, m0_a_ready}, 32'd0);
               @(posedge clk); #1;
               if (k == 4) m1_d_ready = 1'b1;
               @(negedge clk);
            end
            hs_cyc = cyc;
         end
      join
      chk("grant_after_handshake", t0, hs_cyc + 1);
      repeat (4) @(posedge clk); #1;

      // 6: reset in CAPTURE drops the transaction; rr pointer restarts at m0
      issue(0, 3'd4, 4'd2, 4'h0, 32'h60, 32'h0, 32'hA000_0018, t0);
      @(posedge clk);
      set_a(0, 1'b1, 3'd4, 4'd2, 4'h0, 32'h64, 32'h0);
      set_a(1, 1'b1, 3'd4, 4'd2, 4'h0, 32'h68, 32'h0);
      #2 rst_n = 1'b0;
      dq.delete();
      sq.delete();
      #1 check_outputs_zero("mid_reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      grant_m.delete();
      grant_t.delete();
      fork
         issue(0, 3'd4, 4'd2, 4'h0, 32'h64, 32'h0, 32'hA000_0019, t0);
         issue(1, 3'd4, 4'd2, 4'h0, 32'h68, 32'h0, 32'hA000_001A, t1);
      join
      chk("post_reset_count", grant_m.size(), 2);
      if (grant_m.size() == 2) begin
         chk("post_reset_first", grant_m[0], 0);
         chk("post_reset_second", grant_m[1], 1);
      end
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("dq_drained", dq.size(), 0);
      chk("sq_drained", sq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
